// File: rtl/hex_display_driver.sv
// Multi-digit active-low 7-segment hex driver: one shared decoder, one digit per clock, atomic commit.
// Optional HEX_BLINK_EN macro adds per-digit blinking driven by a free-running BLINK_DIV counter.
module hex_display_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic                      ready,
  output logic                      done,
  output logic [8*NUM_DIGITS-1:0]   HEX
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t                         state_q, state_d;
  logic [4*NUM_DIGITS-1:0]        val_q;
  logic [NUM_DIGITS-1:0]          dp_q;
  logic                           blz_q;
  logic [IW-1:0]                  idx_q;
  logic                           seen_q;
  logic [NUM_DIGITS-1:0][7:0]     shadow_q;
  logic [NUM_DIGITS-1:0][7:0]     hex_q;
  logic                           done_q;

  logic [3:0]                     digit;
  logic                           nz;
  logic                           blank;
  logic [7:0]                     glyph_byte;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h27;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (load) state_d = CONVERT;
      end
      CONVERT: if (idx_q == '0) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Leading zeros blank the segments only; the decimal point is kept regardless.
  always_comb begin
    digit      = val_q[{idx_q, 2'b00} +: 4];
    nz         = (digit != 4'h0);
    blank      = blz_q && !seen_q && !nz && (idx_q != '0);
    glyph_byte = {~dp_q[idx_q], blank ? 7'h7F : glyph(digit)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q    <= '0;
      dp_q     <= '0;
      blz_q    <= 1'b0;
      idx_q    <= '0;
      seen_q   <= 1'b0;
      shadow_q <= '0;
      hex_q    <= '1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (load) begin
          val_q  <= value;
          dp_q   <= dp_in;
          blz_q  <= blank_lz;
          idx_q  <= IW'(NUM_DIGITS - 1);
          seen_q <= 1'b0;
        end
        CONVERT: begin
          shadow_q[idx_q] <= glyph_byte;
          seen_q          <= seen_q | nz;
          idx_q           <= idx_q - 1'b1;
        end
        COMMIT: begin
          hex_q  <= shadow_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done = done_q;

`ifdef HEX_BLINK_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(BLINK_DIV - 1);

  logic [CW-1:0]         cnt_q;
  logic                  phase_q;
  logic [NUM_DIGITS-1:0] bmask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      bmask_q <= '0;
    end else begin
      if (cnt_q == CMAX) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == IDLE && load) bmask_q <= blink_mask;
    end
  end

  // Masking sits after the committed register so blinking never disturbs its contents.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_blink
    assign HEX[8*k +: 8] = (phase_q && bmask_q[k]) ? 8'hFF : hex_q[k];
  end
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask ^ (BLINK_DIV > 0);
  assign HEX          = hex_q;
`endif

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed bench for hex_display_driver (default build, NUM_DIGITS=6).
module tb_hex_display_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [23:0] value = '0;
  logic [5:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [5:0]  blink_mask = '0;
  logic        ready;
  logic        done;
  logic [47:0] HEX;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  hex_display_driver #(.NUM_DIGITS(6), .BLINK_DIV(4)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .blink_mask(blink_mask), .ready(ready), .done(done), .HEX(HEX)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (done) done_cnt++;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full conversion: E0 accepts, HEX must hold through E6, updates at E7.
  task automatic convert(input string tag, input logic [23:0] v, input logic [5:0] dp,
                         input logic blz, input logic [47:0] exp);
    logic [47:0] prev;
    prev     = HEX;
    value    = v;
    dp_in    = dp;
    blank_lz = blz;
    load     = 1'b1;
    step();
    load = 1'b0;
    chk({tag, "_busy"}, {47'd0, ready}, 48'd0);
    repeat (6) step();
    chk({tag, "_hold"}, HEX, prev);
    step();
    chk({tag, "_hex"}, HEX, exp);
    chk({tag, "_done"}, {46'd0, done, ready}, 48'd3);
    step();
    chk({tag, "_done_off"}, {47'd0, done}, 48'd0);
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("reset_hex", HEX, 48'hFFFF_FFFF_FFFF);
    chk("reset_ctl", {46'd0, ready, done}, 48'd2);
    step();
    step();
    reset = 1'b0;
    step();

    convert("lz", 24'h00F0A3, 6'b000000, 1'b1, 48'hFFFF_8EC0_88B0);
    convert("zero_blz", 24'h000000, 6'b000100, 1'b1, 48'hFFFF_FF7F_FFC0);
    convert("zero_noblz", 24'h000000, 6'b000100, 1'b0, 48'hC0C0_C040_C0C0);
    convert("dp_all", 24'h89ABCD, 6'b111111, 1'b1, 48'h0010_0803_2721);
    convert("glyphs", 24'h4567EF, 6'b000000, 1'b0, 48'h9992_82F8_868E);

    // Busy rejection: second load pulse lands two cycles into the conversion.
    done_cnt = 0;
    value = 24'h123456; dp_in = '0; blank_lz = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    step();
    value = 24'hFFFFFF; load = 1'b1;
    chk("busy_ready", {47'd0, ready}, 48'd0);
    step();
    load = 1'b0;
    repeat (15) step();
    chk("busy_hex", HEX, 48'hF9A4_B099_9282);
    chk("busy_done_cnt", 48'(done_cnt), 48'd1);

    // Reset three cycles into CONVERT aborts without a done or partial update.
    done_cnt = 0;
    value = 24'h654321; load = 1'b1;
    step();
    load = 1'b0;
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    chk("midrst_hex", HEX, 48'hFFFF_FFFF_FFFF);
    step();
    reset = 1'b0;
    repeat (10) step();
    chk("midrst_hold", HEX, 48'hFFFF_FFFF_FFFF);
    chk("midrst_done_cnt", 48'(done_cnt), 48'd0);
    convert("after_rst", 24'h000001, 6'b000000, 1'b1, 48'hFFFF_FFFF_FFF9);

    // load held high: back-to-back conversions; value change while busy ignored.
    done_cnt = 0;
    value = 24'h111111; dp_in = '0; blank_lz = 1'b0; load = 1'b1;
    step();
    value = 24'h222222;
    repeat (6) step();
    chk("b2b_hold", HEX, 48'hFFFF_FFFF_FFF9);
    step();
    chk("b2b_first", HEX, 48'hF9F9_F9F9_F9F9);
    chk("b2b_ready", {46'd0, done, ready}, 48'd3);
    step();
    load = 1'b0;
    chk("b2b_accept", {46'd0, done, ready}, 48'd0);
    repeat (7) step();
    chk("b2b_second", HEX, 48'hA4A4_A4A4_A4A4);
    step();
    chk("b2b_done_cnt", 48'(done_cnt), 48'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
